div_seq: RTL and testbench

- Multi-cycle 32-bit signed/unsigned divider in the EX stage of the 5-stage MIPS pipeline, serving DIV and DIVU.
- It is the source of the EX-stage stall request consumed by the pipeline controller.
- The controller freezes PC/IF/ID/EX (stall = 6'b001111) while the request is high.
- It produces {HI = remainder, LO = quotient} for the HI/LO write path.

---
 rtl/div_seq_pkg.sv | 22 ++
 rtl/div_seq_if.sv | 28 ++
 rtl/div_seq_step.sv | 22 ++
 rtl/div_seq.sv | 95 +++++++++
 tb/tb_div_seq.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/div_seq_pkg.sv
// Shared types and constants for the sequential DIV/DIVU unit.
package div_seq_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = 6;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;
  localparam logic RST_ENABLE           = 1'b1;
  localparam logic STOP                 = 1'b1;
  localparam logic NO_STOP              = 1'b0;

endpackage

// File: rtl/div_seq_if.sv
// EX-stage <-> divider handshake. Handshake: the EX stage raises start and holds it,
// together with stable operands, until it sees ready; ready marks result valid for as
// long as it stays high. Dropping start while ready is high releases the divider.
// annul aborts any operation in flight.
interface div_seq_if
  import div_seq_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
);
  logic               signed_div;
  logic [WIDTH-1:0]   opdata1;
  logic [WIDTH-1:0]   opdata2;
  logic               start;
  logic               annul;
  logic [2*WIDTH-1:0] result;
  logic               ready;
  logic               stallreq;

  modport master (
    output signed_div, opdata1, opdata2, start, annul,
    input  result, ready, stallreq
  );

  modport slave (
    input  signed_div, opdata1, opdata2, start, annul,
    output result, ready, stallreq
  );
endinterface

// File: rtl/div_seq_step.sv
// One restoring-division iteration on the {remainder, quotient} work register.
module div_seq_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] w,
  input  logic [WIDTH-1:0]   divisor,
  output logic [2*WIDTH-1:0] w_next
);
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH-1:0] diff;

  always_comb begin
    // Keep the bit shifted out of the remainder so divisors >= 2^(WIDTH-1) still compare correctly.
    rem_shift = w[2*WIDTH-1:WIDTH-1];
    diff      = rem_shift[WIDTH-1:0] - divisor;
    w_next    = {w[2*WIDTH-2:0], 1'b0};
    if (rem_shift >= {1'b0, divisor}) begin
      w_next[2*WIDTH-1:WIDTH] = diff;
      w_next[0]               = 1'b1;
    end
  end
endmodule

// File: rtl/div_seq.sv
// Multi-cycle signed/unsigned divider for the EX stage; result is {remainder, quotient}.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic       clk,
  input  logic       rst,
  div_seq_if.slave   bus,
  output div_state_e state
);
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] w;
  logic [2*WIDTH-1:0] w_next;
  logic [WIDTH-1:0]   divisor;
  logic               neg_q;
  logic               neg_r;
  logic [2*WIDTH-1:0] result;
  logic               ready;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;

  function automatic logic [WIDTH-1:0] magnitude(input logic sgn, input logic [WIDTH-1:0] v);
    return (sgn && v[WIDTH-1]) ? (~v + 1'b1) : v;
  endfunction

  div_seq_step #(.WIDTH(WIDTH)) u_step (
    .w       (w),
    .divisor (divisor),
    .w_next  (w_next)
  );

  assign quo = neg_q ? (~w[WIDTH-1:0] + 1'b1) : w[WIDTH-1:0];
  assign rem = neg_r ? (~w[2*WIDTH-1:WIDTH] + 1'b1) : w[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state  <= DIV_FREE;
      cnt    <= '0;
      w      <= '0;
      result <= '0;
      ready  <= DIV_RESULT_NOT_READY;
    end else if (bus.annul) begin
      state  <= DIV_FREE;
      cnt    <= '0;
      result <= '0;
      ready  <= DIV_RESULT_NOT_READY;
    end else begin
      case (state)
        DIV_FREE: begin
          result <= '0;
          ready  <= DIV_RESULT_NOT_READY;
          if (bus.start == DIV_START) begin
            // Operands are captured here; later input changes cannot disturb the result.
            divisor <= magnitude(bus.signed_div, bus.opdata2);
            w       <= {{WIDTH{1'b0}}, magnitude(bus.signed_div, bus.opdata1)};
            neg_q   <= bus.signed_div & (bus.opdata1[WIDTH-1] ^ bus.opdata2[WIDTH-1]);
            neg_r   <= bus.signed_div & bus.opdata1[WIDTH-1];
            cnt     <= '0;
            state   <= (bus.opdata2 == '0) ? DIV_BY_ZERO : DIV_ON;
          end
        end
        DIV_BY_ZERO: begin
          result <= '0;
          ready  <= DIV_RESULT_READY;
          state  <= DIV_END;
        end
        DIV_ON: begin
          if (cnt != CNT_W'(WIDTH)) begin
            w   <= w_next;
            cnt <= cnt + 1'b1;
          end else begin
            result <= {rem, quo};
            ready  <= DIV_RESULT_READY;
            state  <= DIV_END;
          end
        end
        DIV_END: begin
          if (bus.start == DIV_STOP) begin
            result <= '0;
            ready  <= DIV_RESULT_NOT_READY;
            state  <= DIV_FREE;
          end
        end
        default: state <= DIV_FREE;
      endcase
    end
  end

  assign bus.result   = result;
  assign bus.ready    = ready;
  assign bus.stallreq = ((rst != RST_ENABLE) && bus.start && (ready != DIV_RESULT_READY) && !bus.annul)
                        ? STOP : NO_STOP;
endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: arithmetic reference model, decoupled result monitor.
module tb_div_seq;
  import div_seq_pkg::*;

  logic       clk;
  logic       rst;
  div_state_e state;
  int         n_checks;
  int         n_fail;
  logic [63:0] exp_q[$];
  logic        ready_d;

  div_seq_if #(.WIDTH(32)) bus ();

  div_seq dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .state (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: true quotient/remainder with truncation toward zero, in 64-bit arithmetic.
  function automatic logic [63:0] model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      sa = longint'(signed'(a));
      sb = longint'(signed'(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // monitor: pops one expectation on every rising ready
  always @(negedge clk) begin
    if (bus.ready && !ready_d) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result: got %h, expected no result", bus.result);
      end else begin
        check("result", bus.result, exp_q.pop_front());
      end
    end
    ready_d = bus.ready;
  end

  // Full division: start held until ready, held `hold` extra cycles in DivEnd, then released.
  task automatic run_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                         input int hold, input bit scramble);
    logic [63:0] exp;
    int edges, stall_hi, exp_lat;
    exp     = model(sgn, a, b);
    exp_lat = (b == 32'd0) ? 1 : 33;
    @(negedge clk);
    bus.annul      = 1'b0;
    bus.signed_div = sgn;
    bus.opdata1    = a;
    bus.opdata2    = b;
    bus.start      = 1'b1;
    exp_q.push_back(exp);
    edges    = 0;
    stall_hi = 0;
    @(posedge clk); #1;
    while (!bus.ready && edges < 100) begin
      if (bus.stallreq) stall_hi++;
      @(posedge clk); #1;
      edges++;
      if (scramble && edges == 5) begin
        bus.opdata1    = $urandom;
        bus.opdata2    = $urandom;
        bus.signed_div = ~sgn;
      end
    end
    check("latency", 64'(edges), 64'(exp_lat));
    check("stall_cycles", 64'(stall_hi), 64'(exp_lat));
    check("stall_at_ready", 64'(bus.stallreq), 64'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_ready", 64'(bus.ready), 64'd1);
      check("hold_result", bus.result, exp);
    end
    bus.start = 1'b0;
    @(posedge clk); #1;
    check("release_ready", 64'(bus.ready), 64'd0);
    check("release_result", bus.result, 64'd0);
    check("release_state", 64'(state), 64'(DIV_FREE));
  endtask

  // Starts a division and kills it with annul or rst after `at_cycle` edges past the start edge.
  task automatic abort_op(input bit use_rst, input int at_cycle);
    @(negedge clk);
    bus.signed_div = 1'b1;
    bus.opdata1    = $urandom;
    bus.opdata2    = $urandom | 32'd1;
    bus.start      = 1'b1;
    @(posedge clk);
    repeat (at_cycle) @(posedge clk);
    @(negedge clk);
    if (use_rst) rst = 1'b1;
    else bus.annul = 1'b1;
    #1;
    check(use_rst ? "stall_in_rst" : "stall_in_annul", 64'(bus.stallreq), 64'd0);
    @(posedge clk); #1;
    check("abort_state", 64'(state), 64'(DIV_FREE));
    check("abort_ready", 64'(bus.ready), 64'd0);
    check("abort_result", bus.result, 64'd0);
    @(negedge clk);
    rst       = 1'b0;
    bus.annul = 1'b0;
    bus.start = 1'b0;
  endtask

  initial begin
    logic [31:0] a, b;
    bit sgn;
    n_checks = 0;
    n_fail   = 0;
    ready_d  = 1'b0;
    rst            = 1'b1;
    bus.signed_div = 1'b0;
    bus.opdata1    = '0;
    bus.opdata2    = '0;
    bus.start      = 1'b0;
    bus.annul      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 64'(state), 64'(DIV_FREE));
    check("reset_ready", 64'(bus.ready), 64'd0);
    check("reset_result", bus.result, 64'd0);
    check("reset_stall", 64'(bus.stallreq), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    check("model_100_7", model(1'b0, 32'd100, 32'd7), {32'd2, 32'd14});
    run_div(1'b0, 32'd100, 32'd7, 3, 1'b0);
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
    run_div(1'b1, 32'd7, 32'hFFFF_FFFE, 1, 1'b0);
    run_div(1'b1, 32'd1234, 32'd0, 1, 1'b0);
    run_div(1'b0, 32'hDEAD_BEEF, 32'd0, 0, 1'b0);
    run_div(1'b0, 32'hFFFF_FFFF, 32'd1, 0, 1'b0);
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 2, 1'b1);
    run_div(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 1'b1);

    abort_op(1'b0, 10);
    run_div(1'b0, 32'd50, 32'd5, 0, 1'b0);
    abort_op(1'b1, 20);
    run_div(1'b1, 32'hFFFF_FF9C, 32'd9, 0, 1'b0);

    for (int i = 0; i < 25; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a   = $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        3:       b = $urandom | 32'h8000_0000;
        default: b = $urandom;
      endcase
      run_div(sgn, a, b, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
